// File: rtl/branch_target_buffer_if.sv
// Resolved-branch update channel from the ID-stage branch generator
// into the branch target buffer.
interface branch_target_buffer_if;
    logic        btb_set;
    logic [31:0] btb_set_pc;
    logic        btb_set_taken;
    logic [31:0] btb_set_target;

    modport master (
        output btb_set,
        output btb_set_pc,
        output btb_set_taken,
        output btb_set_target
    );

    modport slave (
        input btb_set,
        input btb_set_pc,
        input btb_set_taken,
        input btb_set_target
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters; predicts
// the next fetch PC and carries the prediction along to ID.
module branch_target_buffer #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] if_pc,
    output logic        if_pre_token,
    output logic [31:0] if_pre_addr,
    output logic        id_pre_token,
    output logic [31:0] id_pre_addr,
    branch_target_buffer_if.slave upd
);

    localparam int TAG_W = 30 - IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic        token;
        logic [31:0] addr;
    } pred_t;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    tag_t               tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    // Lookup side
    idx_t        rd_idx;
    tag_t        rd_tag;
    logic        rd_hit;
    logic [31:0] seq_pc;

    assign rd_idx = if_pc[IDX_W+1:2];
    assign rd_tag = if_pc[31:IDX_W+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign seq_pc = {if_pc[31:2] + 30'd1, 2'b00};

    assign if_pre_token = rd_hit && ctr_q[rd_idx][1];
    assign if_pre_addr  = if_pre_token ? target_q[rd_idx] : seq_pc;

    // Update side
    idx_t       wr_idx;
    tag_t       wr_tag;
    logic       wr_hit;
    logic [1:0] wr_ctr;
    logic [1:0] ctr_next;

    assign wr_idx = upd.btb_set_pc[IDX_W+1:2];
    assign wr_tag = upd.btb_set_pc[31:IDX_W+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_ctr = ctr_q[wr_idx];

    always_comb begin
        ctr_next = wr_ctr;
        if (upd.btb_set_taken) begin
            if (wr_ctr != 2'd3) ctr_next = wr_ctr + 2'd1;
        end else begin
            if (wr_ctr != 2'd0) ctr_next = wr_ctr - 2'd1;
        end
    end

    // Entries stay valid at ctr=0; only a taken miss replaces a line
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd0;
        end else if (upd.btb_set) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_next;
            end else if (upd.btb_set_taken) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= 2'd2;
            end
        end
    end

    // Payload arrays carry no reset so they can map onto plain RAM
    always_ff @(posedge clk) begin
        if (!rst && upd.btb_set && upd.btb_set_taken) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= upd.btb_set_target;
        end
    end

    // ID-aligned copy of the prediction
    pred_t id_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_q <= '0;
        end else if (!stall) begin
            id_q <= '{token: if_pre_token, addr: if_pre_addr};
        end
    end

    assign id_pre_token = id_q.token;
    assign id_pre_addr  = id_q.addr;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd.btb_set_pc[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer: lookup, counter
// hysteresis, aliasing, ID pipeline control, collision and reset.
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] if_pc;
    logic        if_pre_token;
    logic [31:0] if_pre_addr;
    logic        id_pre_token;
    logic [31:0] id_pre_addr;

    int pass_cnt;
    int total_cnt;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.ENTRIES(64), .IDX_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .if_pc        (if_pc),
        .if_pre_token (if_pre_token),
        .if_pre_addr  (if_pre_addr),
        .id_pre_token (id_pre_token),
        .id_pre_addr  (id_pre_addr),
        .upd          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic update(input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt);
        bus.btb_set        = 1'b1;
        bus.btb_set_pc     = pc;
        bus.btb_set_taken  = tk;
        bus.btb_set_target = tgt;
        step();
        bus.btb_set = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic tk, input logic [31:0] addr);
        if_pc = pc;
        #1;
        total_cnt++;
        if (if_pre_token !== tk || if_pre_addr !== addr)
            $display("FAIL %s: got token=%0b addr=%08h, want token=%0b addr=%08h",
                     name, if_pre_token, if_pre_addr, tk, addr);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if (id_pre_token !== 1'b0 || id_pre_addr !== 32'h0)
            $display("FAIL reset_id: got %0b/%08h, want 0/00000000",
                     id_pre_token, id_pre_addr);
        else
            pass_cnt++;
        look("cold_lookup", 32'hBFC0_0000, 1'b0, 32'hBFC0_0004);
        step();
        total_cnt++;
        if (id_pre_token !== 1'b0 || id_pre_addr !== 32'hBFC0_0004)
            $display("FAIL cold_id: got %0b/%08h, want 0/bfc00004",
                     id_pre_token, id_pre_addr);
        else
            pass_cnt++;
    endtask

    task automatic test_allocate();
        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        look("alloc_if", 32'h8000_0010, 1'b1, 32'h8000_0100);
        step();
        total_cnt++;
        if (id_pre_token !== 1'b1 || id_pre_addr !== 32'h8000_0100)
            $display("FAIL alloc_id: got %0b/%08h, want 1/80000100",
                     id_pre_token, id_pre_addr);
        else
            pass_cnt++;
    endtask

    task automatic test_hysteresis();
        update(32'h8000_0010, 1'b0, 32'h0);
        look("ctr2to1", 32'h8000_0010, 1'b0, 32'h8000_0014);
        update(32'h8000_0010, 1'b0, 32'h0);
        look("ctr1to0", 32'h8000_0010, 1'b0, 32'h8000_0014);
        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        look("ctr0to1", 32'h8000_0010, 1'b0, 32'h8000_0014);
        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        look("ctr1to2", 32'h8000_0010, 1'b1, 32'h8000_0100);
        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        update(32'h8000_0010, 1'b1, 32'h8000_0180);
        look("new_target", 32'h8000_0010, 1'b1, 32'h8000_0180);
        update(32'h8000_0010, 1'b0, 32'h0);
        look("saturate", 32'h8000_0010, 1'b1, 32'h8000_0180);
    endtask

    task automatic test_aliasing();
        look("alias_miss", 32'h8000_0110, 1'b0, 32'h8000_0114);
        update(32'h8000_0110, 1'b0, 32'h0);
        look("alias_nt_keep", 32'h8000_0010, 1'b1, 32'h8000_0180);
        look("alias_nt_miss", 32'h8000_0110, 1'b0, 32'h8000_0114);
        update(32'h8000_0110, 1'b1, 32'h8000_0200);
        look("alias_replace", 32'h8000_0110, 1'b1, 32'h8000_0200);
        look("alias_evicted", 32'h8000_0010, 1'b0, 32'h8000_0014);
        look("low_bits", 32'h8000_0113, 1'b1, 32'h8000_0200);
    endtask

    task automatic test_pipeline();
        if_pc = 32'h8000_0110;
        step();
        total_cnt++;
        if (id_pre_token !== 1'b1 || id_pre_addr !== 32'h8000_0200)
            $display("FAIL pipe_load: got %0b/%08h, want 1/80000200",
                     id_pre_token, id_pre_addr);
        else
            pass_cnt++;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_pc = 32'h0000_1000 + 32'(i) * 32'h1000;
            step();
            total_cnt++;
            if (id_pre_token !== 1'b1 || id_pre_addr !== 32'h8000_0200)
                $display("FAIL pipe_stall%0d: got %0b/%08h, want 1/80000200",
                         i, id_pre_token, id_pre_addr);
            else
                pass_cnt++;
        end
        flush = 1'b1;
        step();
        total_cnt++;
        if (id_pre_token !== 1'b0 || id_pre_addr !== 32'h0)
            $display("FAIL pipe_flush: got %0b/%08h, want 0/00000000",
                     id_pre_token, id_pre_addr);
        else
            pass_cnt++;
        flush = 1'b0;
        stall = 1'b0;
        step();
        total_cnt++;
        if (id_pre_token !== 1'b0 || id_pre_addr !== 32'h0000_2004)
            $display("FAIL pipe_resume: got %0b/%08h, want 0/00002004",
                     id_pre_token, id_pre_addr);
        else
            pass_cnt++;
    endtask

    task automatic test_collision();
        bus.btb_set        = 1'b1;
        bus.btb_set_pc     = 32'h8000_0040;
        bus.btb_set_taken  = 1'b1;
        bus.btb_set_target = 32'h8000_0400;
        look("collide_old", 32'h8000_0040, 1'b0, 32'h8000_0044);
        step();
        bus.btb_set = 1'b0;
        look("collide_new", 32'h8000_0040, 1'b1, 32'h8000_0400);
    endtask

    task automatic test_reset_set();
        logic [31:0] pcs [4];
        pcs[0] = 32'h8000_0080;
        pcs[1] = 32'h8000_0110;
        pcs[2] = 32'h8000_0040;
        pcs[3] = 32'h8000_0010;
        rst                = 1'b1;
        bus.btb_set        = 1'b1;
        bus.btb_set_pc     = 32'h8000_0080;
        bus.btb_set_taken  = 1'b1;
        bus.btb_set_target = 32'h8000_0800;
        step();
        rst         = 1'b0;
        bus.btb_set = 1'b0;
        total_cnt++;
        if (id_pre_token !== 1'b0 || id_pre_addr !== 32'h0)
            $display("FAIL rst_mid_id: got %0b/%08h, want 0/00000000",
                     id_pre_token, id_pre_addr);
        else
            pass_cnt++;
        foreach (pcs[i])
            look($sformatf("rst_miss%0d", i), pcs[i], 1'b0, pcs[i] + 32'd4);
    endtask

    initial begin
        pass_cnt           = 0;
        total_cnt          = 0;
        rst                = 1'b0;
        stall              = 1'b0;
        flush              = 1'b0;
        if_pc              = 32'h0;
        bus.btb_set        = 1'b0;
        bus.btb_set_pc     = 32'h0;
        bus.btb_set_taken  = 1'b0;
        bus.btb_set_target = 32'h0;
        #2;
        test_reset();
        test_allocate();
        test_hysteresis();
        test_aliasing();
        test_pipeline();
        test_collision();
        test_reset_set();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
